// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load alignment unit: load funct3 codes,
// controller state encodings and small funct3 decode helpers.
package load_align_unit_pkg;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;

    typedef enum logic [1:0] {
        LOAD_ST_IDLE = 2'd0,
        LOAD_ST_RD0  = 2'd1,
        LOAD_ST_RD1  = 2'd2,
        LOAD_ST_RESP = 2'd3
    } load_state_e;

    function automatic logic f3IsLegal(input logic [2:0] f3);
        return (f3 == FNC_LB) || (f3 == FNC_LH) || (f3 == FNC_LW) ||
               (f3 == FNC_LBU) || (f3 == FNC_LHU);
    endfunction

    function automatic logic f3IsHalf(input logic [2:0] f3);
        return (f3 == FNC_LH) || (f3 == FNC_LHU);
    endfunction

    function automatic logic f3IsWord(input logic [2:0] f3);
        return (f3 == FNC_LW);
    endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Bus bundle for the load alignment unit: request handshake, DMEM read
// port and response handshake. The unit uses the slave view; the MEM
// stage / DMEM side uses the master view.
interface load_align_unit_if #(
    parameter int ADDR_W = 14,
    parameter int TAG_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [TAG_W-1:0]  req_tag;
    logic              dmem_re;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_rdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_err;

    modport slave (
        input  req_valid, req_funct3, req_addr, req_tag, dmem_rdata, resp_ready,
        output req_ready, dmem_re, dmem_addr, resp_valid, resp_data, resp_tag, resp_err
    );

    modport master (
        output req_valid, req_funct3, req_addr, req_tag, dmem_rdata, resp_ready,
        input  req_ready, dmem_re, dmem_addr, resp_valid, resp_data, resp_tag, resp_err
    );
endinterface

// File: rtl/load_align_unit_extract.sv
// Combinational lane selector: shifts a 64-bit word pair right by the byte
// offset and sign/zero-extends the byte, half or word the load asks for.
module load_extract
    import load_align_unit_pkg::*;
(
    input  logic [63:0] i_pair,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [31:0] w_shifted;

    // Align the addressed byte to bit 0, then extend according to funct3.
    always_comb begin
        w_shifted = 32'(i_pair >> {i_offset, 3'b000});
        o_data    = 32'h0;
        case (i_funct3)
            FNC_LB:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            FNC_LBU: o_data = {24'h0, w_shifted[7:0]};
            FNC_LH:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            FNC_LHU: o_data = {16'h0, w_shifted[15:0]};
            FNC_LW:  o_data = w_shifted;
            default: o_data = 32'h0;
        endcase
    end
endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: accepts a load, reads one or two DMEM words and
// returns the extracted, extended value with a tag. Build option
// MISALIGNED_LOAD_EN enables misaligned LH/LHU/LW (word-crossing loads take
// a second read); without it misaligned loads complete at once with an error.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    load_align_unit_if.slave bus
);
    load_state_e       r_state;
    load_state_e       w_next;
    logic [2:0]        r_funct3;
    logic [1:0]        r_offset;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_cross;
    logic [31:0]       r_word0;
    logic [31:0]       r_resp_data;
    logic [TAG_W-1:0]  r_resp_tag;
    logic              r_resp_err;

    logic              w_accept;
    logic              w_req_err;
    logic              w_req_cross;
    logic [63:0]       w_pair;
    logic [31:0]       w_extract;
    wire               w_unused = &{1'b0, bus.req_addr[31:ADDR_W+2]};

    // Classify the incoming request: illegal/unsupported, and whether it spans two words.
    always_comb begin
        w_req_err   = 1'b0;
        w_req_cross = 1'b0;
`ifdef MISALIGNED_LOAD_EN
        w_req_err   = !f3IsLegal(bus.req_funct3);
        w_req_cross = (f3IsHalf(bus.req_funct3) && (bus.req_addr[1:0] == 2'b11)) ||
                      (f3IsWord(bus.req_funct3) && (bus.req_addr[1:0] != 2'b00));
`else
        w_req_err   = !f3IsLegal(bus.req_funct3) ||
                      (f3IsHalf(bus.req_funct3) && bus.req_addr[0]) ||
                      (f3IsWord(bus.req_funct3) && (bus.req_addr[1:0] != 2'b00));
        w_req_cross = 1'b0;
`endif
    end

    assign w_accept = bus.req_valid && bus.req_ready;
    assign w_pair   = (r_state == LOAD_ST_RD1) ? {bus.dmem_rdata, r_word0}
                                               : {32'h0, bus.dmem_rdata};

    load_extract u_extract (
        .i_pair   (w_pair),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_extract)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= LOAD_ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic plus handshake and DMEM read issue; all gated off while in reset.
    always_comb begin
        w_next        = r_state;
        bus.req_ready = 1'b0;
        bus.dmem_re   = 1'b0;
        bus.dmem_addr = bus.req_addr[ADDR_W+1:2];
        case (r_state)
            LOAD_ST_IDLE: begin
                bus.req_ready = rst_n;
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next = LOAD_ST_RESP;
                    end else begin
                        w_next      = LOAD_ST_RD0;
                        bus.dmem_re = 1'b1;
                    end
                end
            end
            LOAD_ST_RD0: begin
                if (r_cross) begin
                    w_next        = LOAD_ST_RD1;
                    bus.dmem_re   = rst_n;
                    bus.dmem_addr = r_waddr + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    w_next = LOAD_ST_RESP;
                end
            end
            LOAD_ST_RD1:  w_next = LOAD_ST_RESP;
            LOAD_ST_RESP: if (bus.resp_ready) w_next = LOAD_ST_IDLE;
            default:      w_next = LOAD_ST_IDLE;
        endcase
    end

    // Request capture, first-word buffering and response result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_funct3    <= 3'b000;
            r_offset    <= 2'b00;
            r_waddr     <= '0;
            r_cross     <= 1'b0;
            r_word0     <= 32'h0;
            r_resp_data <= 32'h0;
            r_resp_tag  <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                LOAD_ST_IDLE: begin
                    if (w_accept) begin
                        r_funct3   <= bus.req_funct3;
                        r_offset   <= bus.req_addr[1:0];
                        r_waddr    <= bus.req_addr[ADDR_W+1:2];
                        r_cross    <= w_req_cross;
                        r_resp_tag <= bus.req_tag;
                        if (w_req_err) begin
                            r_resp_data <= 32'h0;
                            r_resp_err  <= 1'b1;
                        end
                    end
                end
                LOAD_ST_RD0: begin
                    if (r_cross) begin
                        r_word0 <= bus.dmem_rdata;
                    end else begin
                        r_resp_data <= w_extract;
                        r_resp_err  <= 1'b0;
                    end
                end
                LOAD_ST_RD1: begin
                    r_resp_data <= w_extract;
                    r_resp_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_valid = (r_state == LOAD_ST_RESP);
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_tag   = r_resp_tag;
    assign bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit with a behavioural synchronous DMEM.
// Expected values are hand-computed from the DMEM contents below; the
// misaligned cases follow whichever build (MISALIGNED_LOAD_EN) is compiled.
module tb_load_align_unit;
    import load_align_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    load_align_unit_if #(.ADDR_W(14), .TAG_W(5)) bus ();

    load_align_unit #(.ADDR_W(14), .TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMEM contents used by the directed vectors.
    function automatic logic [31:0] memWord(input logic [13:0] a);
        case (a)
            14'h0040: return 32'h8899AABB;
            14'h0041: return 32'h11223344;
            14'h3FFF: return 32'hDEADBEEF;
            14'h0000: return 32'hCAFEF00D;
            default:  return {18'h0, a};
        endcase
    endfunction

    // Synchronous DMEM: data is only meaningful the cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        if (bus.dmem_re) bus.dmem_rdata <= memWord(bus.dmem_addr);
        else             bus.dmem_rdata <= 32'hBAD0BAD0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] tag);
        bus.req_valid  = valid;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_tag    = tag;
    endtask

    // One complete load: issue, count cycles to response, log reads, check result, retire.
    task automatic doLoad(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] tag, input logic [31:0] expData, input logic expErr,
                          input int expLat, input int expReads,
                          input logic [13:0] expA0, input logic [13:0] expA1);
        int lat;
        int reads;
        logic [13:0] a0;
        logic [13:0] a1;
        reads = 0;
        a0 = '0;
        a1 = '0;
        applyStimulus(1'b1, f3, addr, tag);
        #1;
        checkOutput({name, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        if (bus.dmem_re) begin
            a0 = bus.dmem_addr;
            reads++;
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 3'b000, 32'h0, 5'h0);
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            if (bus.dmem_re) begin
                if (reads == 0) a0 = bus.dmem_addr;
                else            a1 = bus.dmem_addr;
                reads++;
            end
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
        checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, "_data"}, bus.resp_data, expData);
        checkOutput({name, "_err"}, 32'(bus.resp_err), 32'(expErr));
        checkOutput({name, "_tag"}, 32'(bus.resp_tag), 32'(tag));
        checkOutput({name, "_reads"}, 32'(reads), 32'(expReads));
        checkOutput({name, "_addr0"}, 32'(a0), 32'(expA0));
        checkOutput({name, "_addr1"}, 32'(a1), 32'(expA1));
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        checkOutput({name, "_retired"}, 32'(bus.resp_valid), 32'd0);
    endtask

    // Hard stop if something wedges the sequence below.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.resp_ready = 1'b0;
        applyStimulus(1'b1, FNC_LW, 32'h100, 5'h1);

        // Reset: gated handshake while low, cleared response after the edge.
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_dmem_re", 32'(bus.dmem_re), 32'd0);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_resp_data", bus.resp_data, 32'h0);
        checkOutput("rst_resp_tag", 32'(bus.resp_tag), 32'd0);
        checkOutput("rst_resp_err", 32'(bus.resp_err), 32'd0);
        applyStimulus(1'b0, 3'b000, 32'h0, 5'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        // Aligned loads.
        doLoad("lw_100",  FNC_LW,  32'h100, 5'h03, 32'h8899AABB, 1'b0, 2, 1, 14'h40, 14'h0);
        doLoad("lb_101",  FNC_LB,  32'h101, 5'h04, 32'hFFFFFFAA, 1'b0, 2, 1, 14'h40, 14'h0);
        doLoad("lbu_101", FNC_LBU, 32'h101, 5'h05, 32'h000000AA, 1'b0, 2, 1, 14'h40, 14'h0);
        doLoad("lh_102",  FNC_LH,  32'h102, 5'h06, 32'hFFFF8899, 1'b0, 2, 1, 14'h40, 14'h0);
        doLoad("lhu_102", FNC_LHU, 32'h102, 5'h07, 32'h00008899, 1'b0, 2, 1, 14'h40, 14'h0);
        doLoad("lb_103",  FNC_LB,  32'h103, 5'h08, 32'hFFFFFF88, 1'b0, 2, 1, 14'h40, 14'h0);
        doLoad("lw_104",  FNC_LW,  32'h104, 5'h09, 32'h11223344, 1'b0, 2, 1, 14'h41, 14'h0);

        // Misaligned loads.
`ifdef MISALIGNED_LOAD_EN
        doLoad("lw_103",   FNC_LW,  32'h103,  5'h0A, 32'h22334488, 1'b0, 3, 2, 14'h40, 14'h41);
        doLoad("lw_fffd",  FNC_LW,  32'hFFFD, 5'h0B, 32'h0DDEADBE, 1'b0, 3, 2, 14'h3FFF, 14'h0);
        doLoad("lhu_103",  FNC_LHU, 32'h103,  5'h0C, 32'h00004488, 1'b0, 3, 2, 14'h40, 14'h41);
        doLoad("lh_101",   FNC_LH,  32'h101,  5'h0D, 32'hFFFF99AA, 1'b0, 2, 1, 14'h40, 14'h0);
`else
        doLoad("lw_103",   FNC_LW,  32'h103,  5'h0A, 32'h0, 1'b1, 1, 0, 14'h0, 14'h0);
        doLoad("lw_fffd",  FNC_LW,  32'hFFFD, 5'h0B, 32'h0, 1'b1, 1, 0, 14'h0, 14'h0);
        doLoad("lhu_103",  FNC_LHU, 32'h103,  5'h0C, 32'h0, 1'b1, 1, 0, 14'h0, 14'h0);
        doLoad("lh_101",   FNC_LH,  32'h101,  5'h0D, 32'h0, 1'b1, 1, 0, 14'h0, 14'h0);
`endif

        // Illegal funct3 codes.
        doLoad("f3_011", 3'b011, 32'h100, 5'h15, 32'h0, 1'b1, 1, 0, 14'h0, 14'h0);
        doLoad("f3_110", 3'b110, 32'h100, 5'h16, 32'h0, 1'b1, 1, 0, 14'h0, 14'h0);
        doLoad("f3_111", 3'b111, 32'h100, 5'h1F, 32'h0, 1'b1, 1, 0, 14'h0, 14'h0);

        // Back-pressure: response held stable, no new request taken.
        applyStimulus(1'b1, FNC_LW, 32'h100, 5'h07);
        @(posedge clk); #1;
        applyStimulus(1'b1, FNC_LB, 32'h204, 5'h09);
        n = 0;
        while (!bus.resp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput("hold_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("hold_data", bus.resp_data, 32'h8899AABB);
            checkOutput("hold_tag", 32'(bus.resp_tag), 32'd7);
            checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
            checkOutput("hold_dmem_re", 32'(bus.dmem_re), 32'd0);
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 3'b000, 32'h0, 5'h0);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        checkOutput("hold_retired", 32'(bus.resp_valid), 32'd0);

        // Reset in the cycle after accept abandons the load.
`ifdef MISALIGNED_LOAD_EN
        applyStimulus(1'b1, FNC_LW, 32'h103, 5'h11);
`else
        applyStimulus(1'b1, FNC_LW, 32'h100, 5'h11);
`endif
        @(posedge clk); #1;
        applyStimulus(1'b0, 3'b000, 32'h0, 5'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_dmem_re", 32'(bus.dmem_re), 32'd0);
        checkOutput("abort_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("abort_req_ready_after", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
            @(posedge clk); #1;
        end

        // Unit still works after the abort.
        doLoad("lw_after", FNC_LW, 32'h100, 5'h12, 32'h8899AABB, 1'b0, 2, 1, 14'h40, 14'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
